// File: rtl/pit_dncnt_if.sv
// pit_dncnt_if: CPU-side register bus of the pit_dncnt interval timer
//   pre_d/pre_ld : prescaler reload value and write strobe
//   div_d/div_ld : divider reload value and write strobe
//   pre_q/div_q  : live prescaler and divider counts
//   pre_bo       : prescaler borrow-out
//   tint         : one-cycle timer interrupt pulse
//   active       : timer running (prescaler reload non-zero)
interface pit_dncnt_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] pre_d, div_d, pre_q, div_q;
  logic pre_ld, div_ld, pre_bo, tint, active;
  modport master(output pre_d, pre_ld, div_d, div_ld, input pre_q, div_q, pre_bo, tint, active);
  modport slave(input pre_d, pre_ld, div_d, div_ld, output pre_q, div_q, pre_bo, tint, active);
endinterface

// File: rtl/pit_dncnt.sv
// pit_dncnt: interval timer from a reloading prescaler cascaded into a reloading divider
//   clk  : system clock, rising edge
//   resl : asynchronous active-low reset
//   bus  : pit_dncnt_if slave (reload writes, live counts, borrow, interrupt, active)
module pit_dncnt #(parameter int WIDTH = 16) (
  input logic clk,
  input logic resl,
  pit_dncnt_if.slave bus
);
  logic [WIDTH-1:0] pre_rl, div_rl, pre_q, div_q;
  logic active, pre_bo, div_step, tint;
  assign active = |pre_rl;
  assign pre_bo = active & ~|pre_q & ~bus.pre_ld;
  // a divider load takes priority over a step and swallows that cycle's interrupt
  assign div_step = pre_bo & ~bus.div_ld;
  always_ff @(posedge clk or negedge resl)
    if (!resl) begin
      pre_rl <= '0;
      div_rl <= '0;
      pre_q <= '0;
      div_q <= '0;
      tint <= 1'b0;
    end else begin
      if (bus.pre_ld) begin
        pre_rl <= bus.pre_d;
        pre_q <= bus.pre_d;
      end else if (active) pre_q <= |pre_q ? pre_q - WIDTH'(1) : pre_rl;
      if (bus.div_ld) begin
        div_rl <= bus.div_d;
        div_q <= bus.div_d;
      end else if (div_step) div_q <= |div_q ? div_q - WIDTH'(1) : div_rl;
      tint <= div_step & ~|div_q;
    end
  assign bus.pre_q = pre_q;
  assign bus.div_q = div_q;
  assign bus.pre_bo = pre_bo;
  assign bus.tint = tint;
  assign bus.active = active;
endmodule

// File: tb/tb_pit_dncnt.sv
// tb_pit_dncnt: directed self-checking bench for pit_dncnt at WIDTH=4
module tb_pit_dncnt;
  localparam int W = 4;
  logic clk = 1'b0;
  logic resl = 1'b0;
  int total = 0;
  int bad = 0;
  int first, second;
  pit_dncnt_if #(.WIDTH(W)) bus();
  pit_dncnt #(.WIDTH(W)) dut(.clk(clk), .resl(resl), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic pl, input logic [W-1:0] pd, input logic dl, input logic [W-1:0] dd);
    bus.pre_ld = pl;
    bus.pre_d = pd;
    bus.div_ld = dl;
    bus.div_d = dd;
    tick();
    bus.pre_ld = 1'b0;
    bus.div_ld = 1'b0;
  endtask
  initial begin
    bus.pre_d = '0;
    bus.div_d = '0;
    bus.pre_ld = 1'b0;
    bus.div_ld = 1'b0;
    #2;
    chk("rst_pre_q", 32'(bus.pre_q), 0);
    chk("rst_div_q", 32'(bus.div_q), 0);
    chk("rst_pre_bo", 32'(bus.pre_bo), 0);
    chk("rst_tint", 32'(bus.tint), 0);
    chk("rst_active", 32'(bus.active), 0);
    #1 resl = 1'b1;
    tick();
    load(1'b1, 4'd3, 1'b1, 4'd1);
    chk("bp0_pre_q", 32'(bus.pre_q), 3);
    chk("bp0_div_q", 32'(bus.div_q), 1);
    chk("bp0_active", 32'(bus.active), 1);
    chk("bp0_pre_bo", 32'(bus.pre_bo), 0);
    for (int n = 1; n <= 17; n++) begin
      tick();
      chk("bp_pre_q", 32'(bus.pre_q), 3 - (n % 4));
      chk("bp_div_q", 32'(bus.div_q), ((n / 4) % 2 == 0) ? 1 : 0);
      chk("bp_pre_bo", 32'(bus.pre_bo), (n % 4 == 3) ? 1 : 0);
      chk("bp_tint", 32'(bus.tint), (n % 8 == 0) ? 1 : 0);
    end
    load(1'b1, 4'd2, 1'b1, 4'd0);
    chk("d1_pre_q0", 32'(bus.pre_q), 2);
    chk("d1_div_q0", 32'(bus.div_q), 0);
    for (int n = 1; n <= 9; n++) begin
      tick();
      chk("d1_pre_q", 32'(bus.pre_q), 2 - (n % 3));
      chk("d1_div_q", 32'(bus.div_q), 0);
      chk("d1_tint", 32'(bus.tint), (n % 3 == 0) ? 1 : 0);
    end
    load(1'b1, 4'd2, 1'b1, 4'd5);
    repeat (4) tick();
    chk("dis_pre_q_pre", 32'(bus.pre_q), 1);
    chk("dis_div_q_pre", 32'(bus.div_q), 4);
    load(1'b1, 4'd0, 1'b0, 4'd0);
    chk("dis_active", 32'(bus.active), 0);
    chk("dis_pre_q", 32'(bus.pre_q), 0);
    chk("dis_pre_bo", 32'(bus.pre_bo), 0);
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("dis_hold_pre_q", 32'(bus.pre_q), 0);
      chk("dis_hold_div_q", 32'(bus.div_q), 4);
      chk("dis_hold_pre_bo", 32'(bus.pre_bo), 0);
      chk("dis_hold_tint", 32'(bus.tint), 0);
    end
    load(1'b1, 4'd4, 1'b0, 4'd0);
    chk("res_active", 32'(bus.active), 1);
    chk("res_pre_q", 32'(bus.pre_q), 4);
    tick();
    chk("res_pre_q_dec", 32'(bus.pre_q), 3);
    chk("res_div_q", 32'(bus.div_q), 4);
    load(1'b1, 4'd1, 1'b1, 4'd0);
    tick();
    chk("col_pre_bo", 32'(bus.pre_bo), 1);
    chk("col_div_q0", 32'(bus.div_q), 0);
    load(1'b0, 4'd0, 1'b1, 4'd7);
    chk("col_div_q", 32'(bus.div_q), 7);
    chk("col_tint", 32'(bus.tint), 0);
    chk("col_pre_q", 32'(bus.pre_q), 1);
    tick();
    chk("col_tint_after", 32'(bus.tint), 0);
    load(1'b1, 4'd15, 1'b1, 4'd15);
    first = 0;
    second = 0;
    for (int c = 1; c <= 600; c++) begin
      tick();
      if (bus.tint === 1'b1) begin
        if (first == 0) first = c;
        else if (second == 0) second = c;
      end
      if (second != 0) break;
    end
    chk("max_first_tint", 32'(first), 256);
    chk("max_second_tint", 32'(second), 512);
    load(1'b1, 4'd5, 1'b1, 4'd2);
    chk("ar_pre_q_pre", 32'(bus.pre_q), 5);
    chk("ar_div_q_pre", 32'(bus.div_q), 2);
    #2 resl = 1'b0;
    #1;
    chk("ar_pre_q", 32'(bus.pre_q), 0);
    chk("ar_div_q", 32'(bus.div_q), 0);
    chk("ar_tint", 32'(bus.tint), 0);
    chk("ar_active", 32'(bus.active), 0);
    chk("ar_pre_bo", 32'(bus.pre_bo), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pit_dncnt.md
Name: pit_dncnt

Overview:
Programmable interval timer built from two cascaded loadable down-counters. It is the count-down counterpart to the up-counter slices used elsewhere in Tom. A prescaler counts down on every clock and reloads from its reload register when it underflows. Each prescaler underflow steps a divider down-counter. Divider underflow reloads the divider and raises a one-cycle timer interrupt pulse (tint) toward the interrupt controller, with readback of both live counts for the CPU register interface.

Parameters:
WIDTH, 16, width of prescaler and divider counters and reload registers

Ports:
clk  input  1  system clock; all state changes on rising edge
resl  input  1  asynchronous active-low reset
pre_d  input  WIDTH  prescaler reload value from CPU write data
pre_ld  input  1  prescaler write strobe; one clk per write
div_d  input  WIDTH  divider reload value from CPU write data
div_ld  input  1  divider write strobe; one clk per write
pre_q  output  WIDTH  live prescaler count (readback)
div_q  output  WIDTH  live divider count (readback)
pre_bo  output  1  prescaler borrow-out, combinational
tint  output  1  registered one-cycle timer interrupt pulse
active  output  1  timer running; high when the prescaler reload register is non-zero

Behaviour:
- Reset (resl low, async, any time including mid-count): pre_rl, div_rl, pre_q and div_q = 0; tint = 0; active = 0; pre_bo = 0.
- Writes:
  - pre_ld at an edge: pre_rl <= pre_d and pre_q <= pre_d. Prescaler does not decrement that cycle.
  - div_ld at an edge: div_rl <= div_d and div_q <= div_d.
  - Both strobes in the same cycle are independent and both take effect.
- active = (pre_rl != 0). Writing pre_d = 0 stops the timer.
- When inactive:
  - pre_q and div_q hold their values.
  - pre_bo = 0 and tint = 0.
  - Loads still apply.
- pre_bo = active & (pre_q == 0) & ~pre_ld.
- Prescaler, per edge when active and no pre_ld:
  - pre_q == 0 -> pre_q <= pre_rl (wrap, no underflow to all-ones).
  - Otherwise pre_q <= pre_q - 1.
- div_step = pre_bo & ~div_ld. A load wins over a step and suppresses tint that cycle.
- Divider, per edge with div_step:
  - div_q == 0 -> div_q <= div_rl and tint <= 1.
  - Otherwise div_q <= div_q - 1 and tint <= 0.
- tint <= 0 on every edge without a divider wrap. tint is therefore high exactly one clk, beginning after the wrap edge.
- Period: with reload values P != 0 and D, tint repeats every (P+1)*(D+1) clks.
  - D = 0 gives a tint every prescaler period.
  - P = all-ones and D = all-ones is the maximum period, 2^(2*WIDTH) clks; no overflow state exists.
- Mid-count pre_ld restarts the prescaler from the new value. div_q is unaffected unless div_ld is also asserted.
- Counter arithmetic is modulo 2^WIDTH, but the wrap rule above means pre_q never goes below 0 while active.

Test Plan:
- Reset: drive resl low mid-count with pre_q = 5 and div_q = 2 -> all outputs 0 immediately, without waiting for a clk edge.
- Basic period: load pre_d = 3, div_d = 1 at edge 0.
  - pre_q sequence 3,2,1,0,3,...
  - pre_bo high in the cycles before edges 4, 8, 12, ...
  - div_q: 1 -> 0 at edge 4, wraps to 1 at edge 8.
  - tint high only between edges 8 and 9, then again between 16 and 17.
- Divide-by-one: pre_d = 2, div_d = 0 -> tint every 3 clks, div_q stays 0.
- Disable: during running, write pre_d = 0 -> active falls after that edge.
  - pre_q = 0, no further pre_bo or tint.
  - div_q frozen.
  - Rewrite pre_d = 4 -> counting resumes from 4.
- Collision: assert div_ld with div_d = 7 in the same cycle pre_bo = 1 and div_q = 0 -> div_q = 7 and no tint pulse.
- Max values: WIDTH = 4, P = 15, D = 15 -> tint every 256 clks.
